// File: rtl/seven_seg_pkg.sv
// Shared constants and state types for the scanned two-digit 7-segment controller.
package seven_seg_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } load_state_e;

    typedef enum logic [1:0] {
        RIGHT,
        BLANK_R,
        LEFT,
        BLANK_L
    } scan_phase_e;

endpackage

// File: rtl/bcd_to_seven_segment.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes render blank.
module bcd_to_seven_segment
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Accepts a 0-99 value, converts it to two digits by repeated subtraction, and scans both
// digits onto one shared segment bus. Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] decimalNumber,
    input  logic       loadValid,
    output logic       loadReady,
    output logic       busy,
    output logic [6:0] segments,
    output logic [1:0] digitEnable,
    output logic       overflowError
);

    localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);

    load_state_e state_q, state_d;
    logic [6:0]  rem_q, rem_d;
    logic [3:0]  tens_q, tens_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [3:0]  shown_tens_q, shown_tens_d;
    logic [3:0]  shown_units_q, shown_units_d;
    logic        dash_q, dash_d;
    logic        overflow_q, overflow_d;

    scan_phase_e      phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] sel_digit;
    logic [6:0] sel_seg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            tens_q        <= '0;
            ovf_pend_q    <= 1'b0;
            shown_tens_q  <= '0;
            shown_units_q <= '0;
            dash_q        <= 1'b0;
            overflow_q    <= 1'b0;
            phase_q       <= RIGHT;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            tens_q        <= tens_d;
            ovf_pend_q    <= ovf_pend_d;
            shown_tens_q  <= shown_tens_d;
            shown_units_q <= shown_units_d;
            dash_q        <= dash_d;
            overflow_q    <= overflow_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (loadValid) state_d = (decimalNumber > 7'd99) ? COMMIT : CONVERT;
            CONVERT: if (rem_q < 7'd10) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath; the shown digits only change in COMMIT so the display never tears.
    always_comb begin
        rem_d         = rem_q;
        tens_d        = tens_q;
        ovf_pend_d    = ovf_pend_q;
        shown_tens_d  = shown_tens_q;
        shown_units_d = shown_units_q;
        dash_d        = dash_q;
        overflow_d    = overflow_q;
        case (state_q)
            IDLE: begin
                if (loadValid) begin
                    rem_d      = decimalNumber;
                    tens_d     = '0;
                    ovf_pend_d = (decimalNumber > 7'd99);
                end
            end
            CONVERT: begin
                if (rem_q >= 7'd10) begin
                    rem_d  = rem_q - 7'd10;
                    tens_d = tens_q + 4'd1;
                end
            end
            COMMIT: begin
                shown_tens_d  = tens_q;
                shown_units_d = rem_q[3:0];
                dash_d        = ovf_pend_q;
                overflow_d    = ovf_pend_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        loadReady     = (state_q == IDLE);
        busy          = (state_q != IDLE);
        overflowError = overflow_q;
    end

    // Free-running scan: the counter wraps to zero on every phase change.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        if ((((phase_q == RIGHT) || (phase_q == LEFT)) && (cnt_q == REFRESH_LAST)) ||
            (((phase_q == BLANK_R) || (phase_q == BLANK_L)) && (cnt_q == BLANK_LAST))) begin
            cnt_d = '0;
            case (phase_q)
                RIGHT:   phase_d = BLANK_R;
                BLANK_R: phase_d = LEFT;
                LEFT:    phase_d = BLANK_L;
                default: phase_d = RIGHT;
            endcase
        end
    end

    assign sel_digit = (phase_q == LEFT) ? shown_tens_q : shown_units_q;

    bcd_to_seven_segment u_decode (
        .bcd_i (sel_digit),
        .seg_o (sel_seg)
    );

    always_comb begin
        digitEnable = 2'b00;
        segments    = SEG_BLANK;
        case (phase_q)
            RIGHT: begin
                digitEnable = 2'b01;
                segments    = dash_q ? SEG_DASH : sel_seg;
            end
            LEFT: begin
                digitEnable = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
                segments    = dash_q ? SEG_DASH : ((shown_tens_q == 4'd0) ? SEG_BLANK : sel_seg);
`else
                segments    = dash_q ? SEG_DASH : sel_seg;
`endif
            end
            default: ;
        endcase
    end

endmodule
